// File: rtl/pdm_mic_ctrl.sv
// PDM microphone front-end sequencer: divides clk_i into the mic clock, waits out
// the mic wake-up, then strobes sampled PDM bits into the CIC filter and tracks settling.
module pdm_mic_ctrl #(
    parameter int CLK_DIV        = 4,
    parameter int WAKEUP_CYCLES  = 40000,
    parameter int SETTLE_OUTPUTS = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       pdm_data_i,
    input  logic       filt_out_valid_i,
    output logic       pdm_clk_o,
    output logic       filt_en_o,
    output logic       filt_data_o,
    output logic       filt_valid_o,
    output logic       ready_o,
    output logic [1:0] state_o
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int WK_W  = $clog2(WAKEUP_CYCLES + 1);
    localparam int ST_W  = $clog2(SETTLE_OUTPUTS + 2);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_SAMPLE = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [WK_W-1:0]  WAKE_LAST  = WK_W'(WAKEUP_CYCLES - 1);
    localparam logic [ST_W-1:0]  SETTLE_MAX = ST_W'(SETTLE_OUTPUTS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAKEUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [WK_W-1:0]   wake_cnt_q, wake_cnt_d;
    logic [ST_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic              pdm_clk_q, pdm_clk_d;
    logic              filt_en_q, filt_en_d;
    logic              filt_data_q, filt_data_d;
    logic              filt_valid_q, filt_valid_d;
    logic              ready_q, ready_d;
    logic [DIV_W-1:0]  div_next;

    assign div_next = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = '0;
        wake_cnt_d   = '0;
        settle_cnt_d = '0;
        filt_data_d  = filt_data_q;
        filt_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_i) state_d = WAKEUP;
            end
            WAKEUP: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else begin
                    div_cnt_d  = div_next;
                    wake_cnt_d = wake_cnt_q;
                    if (div_cnt_q == DIV_LAST) begin
                        if (wake_cnt_q == WAKE_LAST) begin
                            state_d    = RUN;
                            wake_cnt_d = '0;
                        end else begin
                            wake_cnt_d = wake_cnt_q + 1'b1;
                        end
                    end
                end
            end
            RUN: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else begin
                    div_cnt_d    = div_next;
                    settle_cnt_d = settle_cnt_q;
                    if (filt_out_valid_i && (settle_cnt_q != SETTLE_MAX))
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    // last cycle of the high phase: mic data is stable here
                    if (div_cnt_q == DIV_SAMPLE) begin
                        filt_data_d  = pdm_data_i;
                        filt_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        pdm_clk_d = (state_d != IDLE) && (div_cnt_d < DIV_HALF);
        filt_en_d = (state_d == RUN);
        ready_d   = (state_d == RUN) && (settle_cnt_d == SETTLE_MAX);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            div_cnt_q    <= '0;
            wake_cnt_q   <= '0;
            settle_cnt_q <= '0;
            pdm_clk_q    <= 1'b0;
            filt_en_q    <= 1'b0;
            filt_data_q  <= 1'b0;
            filt_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            wake_cnt_q   <= wake_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            pdm_clk_q    <= pdm_clk_d;
            filt_en_q    <= filt_en_d;
            filt_data_q  <= filt_data_d;
            filt_valid_q <= filt_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign pdm_clk_o    = pdm_clk_q;
    assign filt_en_o    = filt_en_q;
    assign filt_data_o  = filt_data_q;
    assign filt_valid_o = filt_valid_q;
    assign ready_o      = ready_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_pdm_mic_ctrl.sv
// Self-checking bench for pdm_mic_ctrl: a cycle-age reference model predicts every
// output each cycle; scenario tasks add targeted checks.
module tb_pdm_mic_ctrl;
    localparam int D  = 4;
    localparam int W  = 3;
    localparam int S  = 2;
    localparam int WD = W * D;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       pdm = 1'b0;
    logic       fov = 1'b0;
    logic       pdm_clk_o, filt_en_o, filt_data_o, filt_valid_o, ready_o;
    logic [1:0] state_o;

    int errors = 0;
    int checks = 0;

    // model: active flag, cycles since wake-up start, settle pulses, last sampled bit
    bit         m_active = 1'b0;
    int         m_age = 0;
    int         m_pulses = 0;
    logic       m_data = 1'b0;
    logic [6:0] exp_vec;
    logic [6:0] obs_vec;

    pdm_mic_ctrl #(.CLK_DIV(D), .WAKEUP_CYCLES(W), .SETTLE_OUTPUTS(S)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .pdm_data_i(pdm),
        .filt_out_valid_i(fov), .pdm_clk_o(pdm_clk_o), .filt_en_o(filt_en_o),
        .filt_data_o(filt_data_o), .filt_valid_o(filt_valid_o),
        .ready_o(ready_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        bit run;
        @(posedge clk);
        if (rst) begin
            m_active = 1'b0; m_age = 0; m_pulses = 0; m_data = 1'b0;
        end else if (!m_active) begin
            if (en) begin m_active = 1'b1; m_age = 0; m_pulses = 0; end
        end else if (!en) begin
            m_active = 1'b0;
        end else begin
            if (m_age >= WD) begin
                if (fov) m_pulses++;
                if (m_age % D == D/2 - 1) m_data = pdm;
            end
            m_age++;
        end
        #1;
        if (!m_active) begin
            exp_vec = {2'd0, 1'b0, 1'b0, 1'b0, m_data, 1'b0};
        end else begin
            run = (m_age >= WD);
            exp_vec = {run ? 2'd2 : 2'd1,
                       1'((m_age % D) < D/2),
                       1'(run),
                       1'((m_age >= WD + 1) && ((m_age - 1) % D == D/2 - 1)),
                       m_data,
                       1'(run && (m_pulses >= S))};
        end
        obs_vec = {state_o, pdm_clk_o, filt_en_o, filt_valid_o, filt_data_o, ready_o};
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, obs_vec, exp_vec);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (obs_vec !== 7'd0) begin
                errors++; $display("FAIL idle_quiet cyc=%0d got=%b exp=0000000", i, obs_vec);
            end
        end
    endtask

    task automatic test_wakeup_run();
        int wake_cycles = 0;
        int first_valid = -1;
        int nvalid = 0;
        logic exp_bit;
        en = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            pdm = (k >= 13) ? (((k - 13) >> 2) % 2 == 0) : 1'b0;
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL wake_run k=%0d got=%b exp=%b", k, obs_vec, exp_vec);
            end
            if (state_o == 2'd1) wake_cycles++;
            if (filt_valid_o === 1'b1) begin
                if (first_valid < 0) first_valid = k;
                exp_bit = ((k - 15) / 4) % 2 == 0;
                checks++;
                if (filt_data_o !== exp_bit || (k - 15) % 4 != 0) begin
                    errors++; $display("FAIL strobe_data k=%0d got=%b exp=%b", k, filt_data_o, exp_bit);
                end
                nvalid++;
            end
            if (k == 13) begin
                checks++;
                if (state_o !== 2'd2 || filt_en_o !== 1'b1) begin
                    errors++; $display("FAIL run_entry state=%0d en=%b exp state=2 en=1", state_o, filt_en_o);
                end
            end
        end
        checks++;
        if (wake_cycles != WD) begin
            errors++; $display("FAIL wake_len got=%0d exp=%0d", wake_cycles, WD);
        end
        checks++;
        if (first_valid != 15 || nvalid != 5) begin
            errors++; $display("FAIL first_strobe got=%0d n=%0d exp=15 n=5", first_valid, nvalid);
        end
    endtask

    task automatic test_settle();
        en = 1'b0; step();
        en = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            fov = (k == 5) || (k == 16) || (k == 20) || (k >= 24 && k <= 26);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL settle k=%0d got=%b exp=%b", k, obs_vec, exp_vec);
            end
            if (k == 20) begin
                checks++;
                if (ready_o !== 1'b0) begin
                    errors++; $display("FAIL ready_early got=%b exp=0", ready_o);
                end
            end
            if (k >= 21) begin
                checks++;
                if (ready_o !== 1'b1) begin
                    errors++; $display("FAIL ready_hold k=%0d got=%b exp=1", k, ready_o);
                end
            end
        end
        fov = 1'b0;
    endtask

    task automatic test_stop();
        int budget = 0;
        while (!(state_o == 2'd2 && pdm_clk_o === 1'b1) && budget < 20) begin
            step(); budget++;
        end
        checks++;
        if (budget >= 20) begin
            errors++; $display("FAIL stop_wait got=timeout exp=run_high");
        end
        en = 1'b0;
        step();
        checks++;
        if ({state_o, pdm_clk_o, filt_en_o, filt_valid_o, ready_o} !== 6'd0) begin
            errors++; $display("FAIL stop_outputs got=%b exp=000000", {state_o, pdm_clk_o, filt_en_o, filt_valid_o, ready_o});
        end
        en = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            fov = (k == 14) || (k == 18);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL restart k=%0d got=%b exp=%b", k, obs_vec, exp_vec);
            end
            if (k == 18 || k == 12) begin
                checks++;
                if (ready_o !== 1'b0 || state_o !== ((k == 12) ? 2'd1 : 2'd2)) begin
                    errors++; $display("FAIL restart_state k=%0d ready=%b state=%0d", k, ready_o, state_o);
                end
            end
        end
        fov = 1'b0;
    endtask

    task automatic test_reset_mid();
        en = 1'b0; step();
        en = 1'b1;
        for (int k = 0; k < 6; k++) step();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (state_o !== 2'd0 || obs_vec !== exp_vec) begin
                errors++; $display("FAIL rst_mid got=%b exp=%b", obs_vec, exp_vec);
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if (state_o !== 2'd1 || pdm_clk_o !== 1'b1 || obs_vec !== exp_vec) begin
            errors++; $display("FAIL rst_restart got=%b exp=%b", obs_vec, exp_vec);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            step();
            pdm = 1'($urandom);
            fov = ($urandom_range(0, 3) == 0);
            en  = ($urandom_range(0, 39) != 0);
            rst = ($urandom_range(0, 99) == 0);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL random k=%0d got=%b exp=%b", k, obs_vec, exp_vec);
            end
        end
        rst = 1'b0; en = 1'b0; fov = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wakeup_run();
        test_settle();
        test_stop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pdm_mic_ctrl.md
Name: pdm_mic_ctrl

Overview:
- Sequencer for the PDM front end.
- Generates the microphone PDM clock by dividing the system clock.
- Holds the CIC filter disabled through the microphone wake-up interval, then enables it.
- Samples the mic data pin into a one-cycle data/valid strobe for the filter, and flags when filter output is trustworthy after a settle count.
- Sits between the mic pads and the filter input; drives the filter's enable.

Parameters:
CLK_DIV, 4, system clocks per PDM clock period; even, >= 2
WAKEUP_CYCLES, 40000, PDM clock periods between clock start and filter enable; >= 1
SETTLE_OUTPUTS, 16, filter output samples to count after enable before ready_o asserts; >= 0

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, synchronous, active-high
en_i  in  1  run request; level-sensitive
pdm_data_i  in  1  mic data pin, already synchronised
filt_out_valid_i  in  1  filter output valid, used for settle counting
pdm_clk_o  out  1  mic PDM clock
filt_en_o  out  1  filter enable
filt_data_o  out  1  sampled PDM bit to filter
filt_valid_o  out  1  one-cycle strobe per PDM bit
ready_o  out  1  filter output valid and settled
state_o  out  2  0=IDLE, 1=WAKEUP, 2=RUN

Behaviour:
- Reset (rst_i high at a clock edge) forces:
  - state IDLE.
  - All counters 0.
  - All outputs 0.
  - Reset has priority over en_i.
- Counters:
  - div_cnt: 0..CLK_DIV-1. Cleared in IDLE. Increments every cycle in WAKEUP/RUN and wraps to 0.
  - wake_cnt: counts completed PDM periods in WAKEUP.
  - settle_cnt: counts filt_out_valid_i pulses in RUN, saturates at SETTLE_OUTPUTS.
- pdm_clk_o:
  - Driven directly from a flop (glitch-free).
  - Value each cycle is (state != IDLE) & (div_cnt < CLK_DIV/2), i.e. 50% duty, high phase first.
- IDLE -> WAKEUP when en_i=1. div_cnt=0 in the first WAKEUP cycle.
- WAKEUP -> RUN at the cycle where div_cnt==CLK_DIV-1 and wake_cnt==WAKEUP_CYCLES-1.
  - WAKEUP therefore lasts exactly WAKEUP_CYCLES*CLK_DIV cycles.
  - Clock phase continues unbroken into RUN.
- filt_en_o = (state==RUN), registered.
- In RUN, at each cycle with div_cnt==CLK_DIV/2-1 (last high-phase cycle):
  - Capture pdm_data_i into filt_data_o.
  - Pulse filt_valid_o on the following cycle (latency 1).
  - filt_data_o holds its value between strobes.
- filt_valid_o is never asserted outside RUN, and never in the first RUN cycle unless the sample point coincides.
  - With entry at div_cnt=0, the first strobe is CLK_DIV/2 cycles after RUN entry.
- Settle and ready:
  - settle_cnt increments on filt_out_valid_i only while in RUN.
  - ready_o = (state==RUN) & (settle_cnt==SETTLE_OUTPUTS), registered.
  - If SETTLE_OUTPUTS=0, ready_o is high from the first RUN cycle.
- en_i low in WAKEUP or RUN -> IDLE on the next edge. Same cycle:
  - pdm_clk_o, filt_en_o, filt_valid_o, ready_o go 0.
  - All counters clear.
  - The PDM clock may end mid-high-phase; a truncated high pulse is permitted.
- en_i re-asserted after a stop restarts the full WAKEUP interval. No shortcut.
- filt_out_valid_i pulses in IDLE/WAKEUP are ignored.
- A pulse coincident with the stop cycle is dropped.
- Reset mid-RUN is identical to stop plus clearing filt_data_o.

Test Plan:
(bench params: CLK_DIV=4, WAKEUP_CYCLES=3, SETTLE_OUTPUTS=2)
1. Reset held 3 cycles then released, en_i=0 -> all outputs 0, state_o=0 indefinitely; pdm_clk_o never toggles.
2. en_i=1 at cycle t (state WAKEUP from t+1):
   - pdm_clk_o pattern 1,1,0,0 repeating.
   - state_o=1 for 12 cycles.
   - filt_en_o=1 and state_o=2 from t+13.
   - No filt_valid_o before t+15.
3. In RUN, drive pdm_data_i alternating 1,0 per PDM period:
   - filt_valid_o pulses every 4 cycles, first at t+15.
   - filt_data_o sequence 1,0,1,0 matches the value present at each div_cnt==1 cycle.
4. Pulse filt_out_valid_i once in WAKEUP, then twice in RUN:
   - ready_o stays 0 after the WAKEUP pulse.
   - ready_o goes 1 the cycle after the second RUN pulse.
   - Further pulses keep it 1 (saturation).
5. Drop en_i during a pdm_clk_o high phase in RUN:
   - Next cycle: pdm_clk_o, filt_en_o, ready_o, filt_valid_o all 0; state_o=0.
   - Re-assert en_i: full 12-cycle WAKEUP repeats and ready_o needs 2 new pulses.
6. Assert rst_i mid-WAKEUP with en_i held 1 -> state_o=0 during reset; WAKEUP restarts with div_cnt=0 the cycle after rst_i falls.
